// File: rtl/seq_pattern_tx_if.sv
// Handshake and serial-output bundle for seq_pattern_tx.
// The master side issues requests and observes the serial stream; the slave side is the transmitter.
interface seq_pattern_tx_if #(
  parameter int PAT_W = 8,
  parameter int LEN_W = 4,
  parameter int CNT_W = 4
);
  logic             start_valid;
  logic             start_ready;
  logic [PAT_W-1:0] pat_in;
  logic [LEN_W-1:0] pat_len;
  logic [CNT_W-1:0] rep_cnt;
  logic             abort;
  logic             out_bit;
  logic             out_valid;
  logic             busy;
  logic             done;

  modport master (
    output start_valid, pat_in, pat_len, rep_cnt, abort,
    input  start_ready, out_bit, out_valid, busy, done
  );

  modport slave (
    input  start_valid, pat_in, pat_len, rep_cnt, abort,
    output start_ready, out_bit, out_valid, busy, done
  );
endinterface

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: latches a pattern, length and repeat count on a
// valid/ready handshake and shifts the pattern out MSB-first, one bit per clock,
// with GAP idle cycles between repetitions. Every output comes straight from a flop.
module seq_pattern_tx #(
  parameter int PAT_W = 8,
  parameter int LEN_W = 4,
  parameter int CNT_W = 4,
  parameter int GAP   = 2
) (
  input  logic             clk,
  input  logic             reset,
  seq_pattern_tx_if.slave  bus
);

  localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(PAT_W);
  localparam logic [GAP_W-1:0] GAP_LOAD = (GAP > 0) ? GAP_W'(GAP - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t             r_state;
  logic [PAT_W-1:0]   r_pat;
  logic [IDX_W-1:0]   r_len_m1;
  logic [IDX_W-1:0]   r_idx;
  logic [CNT_W-1:0]   r_reps;
  logic [GAP_W-1:0]   r_gap;
  logic               r_out_bit;
  logic               r_out_valid;
  logic               r_busy;
  logic               r_done;
  logic               r_start_ready;

  state_t             w_state_nxt;
  logic [PAT_W-1:0]   w_pat_nxt;
  logic [IDX_W-1:0]   w_len_m1_nxt;
  logic [IDX_W-1:0]   w_idx_nxt;
  logic [CNT_W-1:0]   w_reps_nxt;
  logic [GAP_W-1:0]   w_gap_nxt;
  logic               w_done_nxt;
  logic               w_valid_nxt;
  logic               w_bit_nxt;

  logic [LEN_W-1:0]   w_len;
  logic [IDX_W-1:0]   w_len_m1;
  logic [CNT_W-1:0]   w_reps;
  logic               w_handshake;

  // Clamp the requested length and repeat count to their legal ranges.
  always_comb begin
    w_len       = ((bus.pat_len == '0) || (bus.pat_len > LEN_MAX)) ? LEN_MAX : bus.pat_len;
    w_len_m1    = IDX_W'(w_len - LEN_W'(1));
    w_reps      = (bus.rep_cnt == '0) ? CNT_W'(1) : bus.rep_cnt;
    w_handshake = bus.start_valid && r_start_ready;
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_pat    <= '0;
      r_len_m1 <= '0;
      r_idx    <= '0;
      r_reps   <= '0;
      r_gap    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_pat    <= w_pat_nxt;
      r_len_m1 <= w_len_m1_nxt;
      r_idx    <= w_idx_nxt;
      r_reps   <= w_reps_nxt;
      r_gap    <= w_gap_nxt;
    end
  end

  // Next-state logic: sequencing of bits, repetitions, gaps and abort.
  always_comb begin
    w_state_nxt  = r_state;
    w_pat_nxt    = r_pat;
    w_len_m1_nxt = r_len_m1;
    w_idx_nxt    = r_idx;
    w_reps_nxt   = r_reps;
    w_gap_nxt    = r_gap;
    w_done_nxt   = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_handshake) begin
          w_pat_nxt    = bus.pat_in;
          w_len_m1_nxt = w_len_m1;
          w_idx_nxt    = w_len_m1;
          w_reps_nxt   = w_reps;
          w_state_nxt  = S_SEND;
        end
      end

      S_SEND: begin
        if (bus.abort) begin
          w_state_nxt = S_IDLE;
        end else if (r_idx != '0) begin
          w_idx_nxt = r_idx - IDX_W'(1);
        end else if (r_reps > CNT_W'(1)) begin
          w_reps_nxt = r_reps - CNT_W'(1);
          w_idx_nxt  = r_len_m1;
          if (GAP == 0) begin
            w_state_nxt = S_SEND;
          end else begin
            w_state_nxt = S_GAP;
            w_gap_nxt   = GAP_LOAD;
          end
        end else begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end
      end

      S_GAP: begin
        if (bus.abort) begin
          w_state_nxt = S_IDLE;
        end else if (r_gap == '0) begin
          w_state_nxt = S_SEND;
        end else begin
          w_gap_nxt = r_gap - GAP_W'(1);
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they can be registered and still
  // line up with the state they describe (first bit the cycle after the handshake).
  always_comb begin
    w_valid_nxt = (w_state_nxt == S_SEND);
    w_bit_nxt   = w_valid_nxt & w_pat_nxt[w_idx_nxt];
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_bit     <= 1'b0;
      r_out_valid   <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_start_ready <= 1'b1;
    end else begin
      r_out_bit     <= w_bit_nxt;
      r_out_valid   <= w_valid_nxt;
      r_busy        <= (w_state_nxt != S_IDLE);
      r_done        <= w_done_nxt;
      r_start_ready <= (w_state_nxt == S_IDLE);
    end
  end

  assign bus.out_bit     = r_out_bit;
  assign bus.out_valid   = r_out_valid;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.start_ready = r_start_ready;

  a_done_idle : assert property (@(posedge clk) disable iff (reset)
    r_done |-> (r_start_ready && !r_busy));
  a_valid_busy : assert property (@(posedge clk) disable iff (reset)
    r_out_valid |-> r_busy);

endmodule
